cpu_bus_master: RTL

- Initiator side of the CPU memory bus: converts CPU load/store requests (byte/half/word, signed/unsigned) into EN_N/WLEN/READY bus transactions.
- Sits between the CPU load/store path and the bus responder that drives READY and rdata.
- Aligns and extends load data, flags misaligned accesses, and aborts hung transactions with a watchdog.

---
 rtl/cpu_bus_pkg.sv | 57 +++++
 rtl/cpu_bus_master_load_align.sv | 26 ++
 rtl/cpu_bus_master.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side bus master: bus opcodes, access sizes,
// master states, and helpers that classify and format a request.
package cpu_bus_pkg;

  localparam int BUS_ADDR_W = 32;

  localparam logic [1:0] WLEN_RD32 = 2'd0;
  localparam logic [1:0] WLEN_WR8  = 2'd1;
  localparam logic [1:0] WLEN_WR16 = 2'd2;
  localparam logic [1:0] WLEN_WR32 = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_RESP,
    ST_ERR
  } mstate_e;

  // A byte store to an odd address is rejected: the responder only has
  // byte-write strobes for the even lane of each halfword.
  function automatic logic access_error(input logic we, input logic [1:0] size,
                                        input logic [1:0] off);
    case (size)
      SZ_BYTE: return we & off[0];
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] wlen_code(input logic we, input logic [1:0] size);
    if (!we) return WLEN_RD32;
    case (size)
      SZ_BYTE: return WLEN_WR8;
      SZ_HALF: return WLEN_WR16;
      default: return WLEN_WR32;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic we, input logic [1:0] size,
                                             input logic [31:0] data);
    if (!we) return 32'd0;
    case (size)
      SZ_BYTE: return {24'd0, data[7:0]};
      SZ_HALF: return {16'd0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_master_load_align.sv
// Load-data lane selection and sign/zero extension. Halfword 0 lives in the
// upper half of the bus word; within a halfword the even byte is the low byte.
module load_align
  import cpu_bus_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  always_comb begin
    half_lane = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    byte_lane = off_i[0] ? half_lane[15:8] : half_lane[7:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      SZ_HALF: data_o = {{16{signed_i & half_lane[15]}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/cpu_bus_master.sv
// CPU load/store request to EN_N/WLEN/READY bus transaction converter with
// misalignment rejection and a watchdog that aborts unanswered transfers.
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [BUS_ADDR_W-1:0] address,
  output logic [31:0]           wdata,
  output logic [1:0]            WLEN,
  output logic                  EN_N,
  input  logic                  READY,
  input  logic [31:0]           rdata
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  mstate_e               state_q;
  logic [WD_W-1:0]       wd_q;
  logic [WD_W-1:0]       wd_d;
  logic                  we_q;
  logic                  signed_q;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [31:0]           resp_rdata_q;
  logic [BUS_ADDR_W-1:0] address_q;
  logic [31:0]           wdata_q;
  logic [1:0]            wlen_q;
  logic                  en_n_q;
  logic [BUS_ADDR_W-1:0] addr_ext;
  logic [31:0]           load_data;

  assign addr_ext = BUS_ADDR_W'(req_addr);
  assign wd_d     = wd_q + WD_W'(1);

  load_align u_load_align (
    .rdata_i  (rdata),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wd_q         <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      address_q    <= '0;
      wdata_q      <= '0;
      wlen_q       <= WLEN_RD32;
      en_n_q       <= 1'b1;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          wd_q        <= '0;
          if (req_ready_q && req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            size_q      <= req_size;
            signed_q    <= req_signed;
            off_q       <= req_addr[1:0];
            if (access_error(req_we, req_size, req_addr[1:0])) begin
              state_q      <= ST_ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              // Bus fields are frozen here so they hold through the whole transfer.
              state_q   <= ST_ARB;
              wlen_q    <= wlen_code(req_we, req_size);
              address_q <= req_we ? addr_ext : {addr_ext[BUS_ADDR_W-1:2], 2'b00};
              wdata_q   <= store_data(req_we, req_size, req_wdata);
            end
          end
        end
        ST_ARB: begin
          if (READY) begin
            state_q <= ST_ISSUE;
            en_n_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_ACK;
          en_n_q  <= 1'b1;
          wd_q    <= WD_W'(1);
        end
        ST_WAIT_ACK: begin
          wd_q <= wd_d;
          if (wd_q == WD_LIMIT) begin
            state_q      <= ST_ERR;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (!READY) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          wd_q <= wd_d;
          if (wd_q == WD_LIMIT) begin
            state_q      <= ST_ERR;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (READY) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? 32'd0 : load_data;
          end
        end
        ST_RESP, ST_ERR: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
          en_n_q      <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign wdata      = wdata_q;
  assign WLEN       = wlen_q;
  assign EN_N       = en_n_q;

endmodule
